alu_seq_unit: RTL

Parametrised MiniMIPS execute-stage ALU that merges ALU-control decoding with the datapath and adds a registered valid/ready interface. It decodes the 2-bit ALUop and 3-bit func field into an internal 4-bit control code and executes the operation. Single-cycle operations complete in 1 cycle. Multiply runs as an iterative shift-add sequencer over WIDTH cycles. It sits between the decode/issue stage and the writeback register.

---
 rtl/alu_seq_unit_if.sv | 29 ++
 rtl/alu_seq_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle for alu_seq_unit.
// master drives requests and takes results; slave is the ALU.
interface alu_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       aluop;
   logic [2:0]       func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;
   logic             err;
   logic [3:0]       alu_ctr;

   modport master (
      output in_valid, aluop, func, a, b, out_ready,
      input  in_ready, out_valid, result, zero, ovf, err, alu_ctr
   );

   modport slave (
      input  in_valid, aluop, func, a, b, out_ready,
      output in_ready, out_valid, result, zero, ovf, err, alu_ctr
   );
endinterface

// File: rtl/alu_seq_unit.sv
// MiniMIPS execute-stage ALU with registered valid/ready output and iterative multiply.
// Define ALU_SEQ_MUL_EN to build the shift-add MUL sequencer; otherwise MUL reports err.
module alu_seq_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic           clk,
   input logic           rst_n,
   alu_seq_unit_if.slave bus
);
   localparam int unsigned SH = $clog2(WIDTH);

   localparam logic [3:0] CtrAnd = 4'd0;
   localparam logic [3:0] CtrOr  = 4'd1;
   localparam logic [3:0] CtrAdd = 4'd2;
   localparam logic [3:0] CtrSub = 4'd3;
   localparam logic [3:0] CtrXor = 4'd4;
   localparam logic [3:0] CtrSlt = 4'd5;
   localparam logic [3:0] CtrSll = 4'd6;
   localparam logic [3:0] CtrMul = 4'd7;

   logic [3:0]       ctr;
   logic [WIDTH-1:0] sum, diff, op_res;
   logic             op_ovf, op_err;
   logic             in_ready, accept, load;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
   logic [3:0]       alu_ctr_q, alu_ctr_d;

   always_comb begin
      case (bus.aluop)
         2'b00:   ctr = CtrAdd;
         2'b01:   ctr = CtrSub;
         2'b10:   ctr = {1'b0, bus.func};
         default: ctr = CtrOr;
      endcase
      sum    = bus.a + bus.b;
      diff   = bus.a - bus.b;
      op_res = '0;
      op_ovf = 1'b0;
      op_err = 1'b0;
      case (ctr)
         CtrAnd: op_res = bus.a & bus.b;
         CtrOr:  op_res = bus.a | bus.b;
         CtrAdd: begin
            op_res = sum;
            op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         CtrSub: begin
            op_res = diff;
            op_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         CtrXor: op_res = bus.a ^ bus.b;
         CtrSlt: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         CtrSll: op_res = bus.a << bus.b[SH-1:0];
`ifdef ALU_SEQ_MUL_EN
         default: op_err = 1'b0;
`else
         default: op_err = 1'b1;
`endif
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
   logic [SH:0]      cnt_q, cnt_d;
   logic             mul_done;

   assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mul_done = 1'b0;
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         StIdle: begin
            if (accept && (ctr == CtrMul)) begin
               state_d  = StMul;
               mcand_d  = bus.a;
               mplier_d = bus.b;
               acc_d    = '0;
               cnt_d    = (SH+1)'(WIDTH);
            end
         end
         StMul: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - (SH+1)'(1);
            // Last iteration: result takes the accumulator including this step.
            if (cnt_q == (SH+1)'(1)) begin
               mul_done = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign load = (accept && (ctr != CtrMul)) || mul_done;
`else
   assign in_ready = rst_n && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign load     = accept;
`endif

   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      alu_ctr_d   = alu_ctr_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (load) begin
         out_valid_d = 1'b1;
`ifdef ALU_SEQ_MUL_EN
         if (mul_done) begin
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            ovf_d     = 1'b0;
            err_d     = 1'b0;
            alu_ctr_d = CtrMul;
         end else begin
`else
         begin
`endif
            result_d  = op_res;
            zero_d    = (op_res == '0);
            ovf_d     = op_ovf;
            err_d     = op_err;
            alu_ctr_d = ctr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         alu_ctr_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         alu_ctr_q   <= alu_ctr_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;
   assign bus.alu_ctr   = alu_ctr_q;
endmodule
